sram_pipelined: RTL

// Single-port byte-enable SRAM with configurable read latency and a response FIFO.

---
 rtl/sram_pipelined_if.sv | 31 +++
 rtl/sram_pipelined.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sram_pipelined_if.sv
// Request/response bus of the pipelined SRAM: req/gnt request channel plus
// rvalid/rready read-return channel. Member names keep the SRAM's own port names.
interface sram_pipelined_if #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int AW         = 10
);
    localparam int BE_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  req_i;
    logic                  gnt_o;
    logic                  we_i;
    logic [AW-1:0]         addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [USER_WIDTH-1:0] wuser_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [USER_WIDTH-1:0] ruser_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, wuser_i, be_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, ruser_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, wuser_i, be_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, ruser_o
    );
endinterface

// File: rtl/sram_pipelined.sv
// Single-port byte-enable SRAM with LATENCY-cycle read pipe and an in-order
// first-word-fall-through response FIFO; read credits guarantee the FIFO never overflows.
module sram_pipelined #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int USER_EN    = 0,
    parameter int NUM_WORDS  = 1024,
    parameter int LATENCY    = 1,
    parameter int RSP_DEPTH  = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sram_pipelined_if.slave bus
);
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("sram_pipelined: LATENCY must be within 1..4");
    end
    if (RSP_DEPTH < 1) begin : g_bad_depth
        $error("sram_pipelined: RSP_DEPTH must be at least 1");
    end

    typedef struct packed {
        logic [USER_WIDTH-1:0] user;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic           rd_acc, wr_acc, push, pop, rvalid;
    logic [CW-1:0]  cnt_q, cnt_d, fcnt_q, fcnt_d;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [USER_WIDTH-1:0] rd_user;
    rsp_t           rd_word, push_word, head;
    rsp_t           fifo_mem [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    // Grant depends only on registered credit state, never on the request itself.
    assign bus.gnt_o = !rst_i && (cnt_q < CW'(RSP_DEPTH));
    assign rd_acc    = bus.req_i && bus.gnt_o && !bus.we_i;
    assign wr_acc    = bus.req_i && bus.gnt_o &&  bus.we_i;

    // NOTE: storage arrays carry no reset; only control state is cleared.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (bus.be_i[i/8]) mem_q[bus.addr_i][i] <= bus.wdata_i[i];
            end
        end
    end

    if (USER_EN != 0) begin : g_user
        logic [USER_WIDTH-1:0] umem_q [NUM_WORDS];
        always_ff @(posedge clk_i) begin
            if (wr_acc && (|bus.be_i)) umem_q[bus.addr_i] <= bus.wuser_i;
        end
        assign rd_user = umem_q[bus.addr_i];
    end else begin : g_no_user
        logic unused_wuser;
        assign unused_wuser = ^bus.wuser_i;
        assign rd_user      = '0;
    end

    // Read-first: the array is sampled before this edge's write lands.
    assign rd_word = '{user: rd_user, data: mem_q[bus.addr_i]};

    if (LATENCY == 1) begin : g_lat1
        assign push      = rd_acc;
        assign push_word = rd_word;
    end else begin : g_pipe
        logic [LATENCY-2:0] pv_q, pv_d;
        rsp_t               pd_q [LATENCY-1];

        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            pv_d    = '0;
            pv_d[0] = rd_acc;
            for (int s = 1; s < LATENCY - 1; s++) pv_d[s] = pv_q[s-1];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) pv_q <= '0;
            else       pv_q <= pv_d;
        end

        always_ff @(posedge clk_i) begin
            pd_q[0] <= rd_word;
            for (int s = 1; s < LATENCY - 1; s++) pd_q[s] <= pd_q[s-1];
        end

        assign push      = pv_q[LATENCY-2];
        assign push_word = pd_q[LATENCY-2];
    end

    assign rvalid = (fcnt_q != '0);
    assign pop    = rvalid && bus.rready_i;

    always_comb begin
        cnt_d  = cnt_q;
        fcnt_d = fcnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (rd_acc && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!rd_acc && pop) cnt_d = cnt_q - 1'b1;
        if (push && !pop)        fcnt_d = fcnt_q + 1'b1;
        else if (!push && pop)   fcnt_d = fcnt_q - 1'b1;
        // Depth need not be a power of two, so wrap explicitly.
        if (push) wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            fcnt_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q] <= push_word;
    end

    always_comb begin
        head         = fifo_mem[rptr_q];
        bus.rvalid_o = rvalid;
        bus.rdata_o  = '0;
        bus.ruser_o  = '0;
        if (rvalid) begin
            bus.rdata_o = head.data;
            bus.ruser_o = head.user;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (fcnt_q == CW'(RSP_DEPTH))));
endmodule
